// File: rtl/program_loader.sv
// Host-side program loader: takes bytes over an async strobe/ack handshake and
// writes them to consecutive RAM addresses through the MAR/RAM load strobes.
module program_loader #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  strobe,
    input  logic                  load_en,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  n_load_addr,
    output logic                  n_load_data,
    output logic                  n_write,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr
);

    typedef enum logic [2:0] {
        IDLE, WAIT_STB, SET_ADDR, SET_DATA, WRITE, ACK, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [DATA_WIDTH-1:0]  bus_out_q, bus_out_d;
    logic                   ack_q, ack_d;
    logic                   bus_oe_q, bus_oe_d;
    logic                   n_load_addr_q, n_load_addr_d;
    logic                   n_load_data_q, n_load_data_d;
    logic                   n_write_q, n_write_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   s_stb, s_en;

    assign s_stb = stb_sync_q[SYNC_STAGES-1];
    assign s_en  = en_sync_q[SYNC_STAGES-1];

    always_comb begin
        stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], strobe};
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], load_en};
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;

        case (state_q)
            IDLE:     if (s_en) state_d = WAIT_STB;
            WAIT_STB: if (s_stb) begin
                hold_d  = data_in;
                state_d = SET_ADDR;
            end
            SET_ADDR: state_d = SET_DATA;
            SET_DATA: state_d = WRITE;
            WRITE:    state_d = ACK;
            // ack is held until the host releases strobe; that release commits the byte
            ACK: if (!s_stb) begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = (addr_q == ADDR_LAST) ? DONE : WAIT_STB;
            end
            DONE:     if (!s_en) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Load request withdrawn mid-load: abandon the partial program
        if (!s_en && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            addr_d  = '0;
        end

        // Outputs decoded from the next state so they are registered with it
        ack_d         = (state_d == ACK);
        bus_oe_d      = (state_d == SET_ADDR) || (state_d == SET_DATA);
        bus_out_d     = '0;
        if (state_d == SET_ADDR) bus_out_d = DATA_WIDTH'(addr_d);
        if (state_d == SET_DATA) bus_out_d = hold_q;
        n_load_addr_d = (state_d != SET_ADDR);
        n_load_data_d = (state_d != SET_DATA);
        n_write_d     = (state_d != WRITE);
        cpu_hold_d    = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stb_sync_q    <= '0;
            en_sync_q     <= '0;
            addr_q        <= '0;
            hold_q        <= '0;
            bus_out_q     <= '0;
            ack_q         <= 1'b0;
            bus_oe_q      <= 1'b0;
            n_load_addr_q <= 1'b1;
            n_load_data_q <= 1'b1;
            n_write_q     <= 1'b1;
            cpu_hold_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stb_sync_q    <= stb_sync_d;
            en_sync_q     <= en_sync_d;
            addr_q        <= addr_d;
            hold_q        <= hold_d;
            bus_out_q     <= bus_out_d;
            ack_q         <= ack_d;
            bus_oe_q      <= bus_oe_d;
            n_load_addr_q <= n_load_addr_d;
            n_load_data_q <= n_load_data_d;
            n_write_q     <= n_write_d;
            cpu_hold_q    <= cpu_hold_d;
            done_q        <= done_d;
        end
    end

    assign ack         = ack_q;
    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign n_load_addr = n_load_addr_q;
    assign n_load_data = n_load_data_q;
    assign n_write     = n_write_q;
    assign cpu_hold    = cpu_hold_q;
    assign done        = done_q;
    assign addr        = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: each byte sent queues its {addr,data};
// the bus monitor pops and compares on every observed RAM write.
module tb_program_loader;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          strobe, load_en;
    logic          ack, bus_oe, n_load_addr, n_load_data, n_write, cpu_hold, done;
    logic [DW-1:0] bus_out;
    logic [AW-1:0] addr;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .strobe(strobe), .load_en(load_en),
        .ack(ack), .bus_out(bus_out), .bus_oe(bus_oe), .n_load_addr(n_load_addr),
        .n_load_data(n_load_data), .n_write(n_write), .cpu_hold(cpu_hold),
        .done(done), .addr(addr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int act_cnt = 0;
    logic [AW+DW-1:0] sb[$];
    logic [DW-1:0] wa, wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Bus monitor: strobe exclusivity, bus_oe qualification, write scoreboard
    always @(negedge clk) begin
        int nlow;
        logic [AW+DW-1:0] e;
        if (rst_n) begin
            nlow = int'(!n_load_addr) + int'(!n_load_data) + int'(!n_write);
            if (nlow != 0) begin
                act_cnt++;
                chk("one_strobe", nlow, 1);
            end
            if (nlow != 0 || bus_oe)
                chk("bus_oe", bus_oe, (!n_load_addr || !n_load_data));
            if (!n_load_addr) wa = bus_out;
            if (!n_load_data) wd = bus_out;
            if (!n_write) begin
                wr_cnt++;
                chk("wr_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", wa, {{(DW-AW){1'b0}}, e[AW+DW-1:DW]});
                    chk("wr_data", wd, e[DW-1:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [DW-1:0] d, input logic [AW-1:0] a,
                             input int hold, input bit detail);
        bit got;
        int w0;
        logic [AW-1:0] na;
        w0 = wr_cnt;
        data_in = d;
        strobe = 1'b1;
        sb.push_back({a, d});
        if (detail) begin
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (!n_load_addr) got = 1;
            end
            chk("set_addr_seen", got, 1);
            chk("set_addr_bus", bus_out, {{(DW-AW){1'b0}}, a});
            @(negedge clk);
            chk("set_data_strb", n_load_data, 0);
            chk("set_data_bus", bus_out, d);
            @(negedge clk);
            chk("write_strb", n_write, 0);
            chk("write_oe", bus_oe, 0);
            @(negedge clk);
            chk("ack_after_wr", ack, 1);
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ack) got = 1;
            else @(negedge clk);
        end
        chk("ack_rise", got, 1);
        repeat (hold) @(negedge clk);
        strobe = 1'b0;
        got = 0;
        for (int i = 0; i < SS + 1 && !got; i++) begin
            @(negedge clk);
            if (!ack) got = 1;
        end
        chk("ack_fall", got, 1);
        na = a + AW'(1);
        chk("addr_next", addr, na);
        chk("one_write", wr_cnt - w0, 1);
    endtask

    initial begin
        int a0;
        bit got;
        rst_n = 1'b0; load_en = 1'b1; strobe = 1'b1; data_in = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_strobes", {n_load_addr, n_load_data, n_write}, 3'b111);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);

        strobe = 1'b0; load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", cpu_hold, 0);
        load_en = 1'b1;
        repeat (SS + 2) @(negedge clk);
        chk("wait_hold", cpu_hold, 1);

        send_byte(8'hA5, 4'd0, 0, 1'b1);

        load_en = 1'b0;
        repeat (SS + 2) @(negedge clk);
        chk("abort1_addr", addr, 0);
        chk("abort1_hold", cpu_hold, 0);
        load_en = 1'b1;
        repeat (SS + 2) @(negedge clk);

        for (int i = 0; i < 16; i++)
            send_byte(8'h10 + DW'(i), AW'(i), (i == 5) ? 20 : 0, 1'b0);
        chk("full_done", done, 1);
        chk("full_hold", cpu_hold, 0);
        chk("full_addr", addr, 0);
        chk("full_sb_empty", sb.size(), 0);

        a0 = act_cnt;
        data_in = 8'hEE; strobe = 1'b1;
        repeat (10) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_no_act", act_cnt - a0, 0);
        chk("done_no_ack", ack, 0);
        chk("done_stays", done, 1);

        load_en = 1'b0;
        repeat (SS + 2) @(negedge clk);
        chk("done_clear", done, 0);
        load_en = 1'b1;
        repeat (SS + 2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            send_byte(8'h30 + DW'(i), AW'(i), 0, 1'b0);
        load_en = 1'b0;
        repeat (SS + 2) @(negedge clk);
        chk("abort2_addr", addr, 0);
        chk("abort2_hold", cpu_hold, 0);
        load_en = 1'b1;
        repeat (SS + 2) @(negedge clk);
        send_byte(8'h77, 4'd0, 0, 1'b0);

        // Async reset landing in the SET_DATA cycle, between clock edges
        data_in = 8'hC3; strobe = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (!n_load_data) got = 1;
        end
        chk("rstmid_reach", got, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_nld", n_load_data, 1);
        chk("rstmid_oe", bus_oe, 0);
        strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_addr", addr, 0);
        chk("rstmid_hold", cpu_hold, 0);
        repeat (SS + 2) @(negedge clk);
        send_byte(8'h5A, 4'd0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
